// File: rtl/jag_pad_pkg.sv
// jag_pad_pkg: joypad button bit indices, column/row matrix map and scanner state encoding
package jag_pad_pkg;
    localparam int NUM_BUTTONS = 21;
    localparam int BTN_PAUSE = 0;
    localparam int BTN_A = 1;
    localparam int BTN_B = 2;
    localparam int BTN_C = 3;
    localparam int BTN_OPTION = 4;
    localparam int BTN_RIGHT = 5;
    localparam int BTN_LEFT = 6;
    localparam int BTN_DOWN = 7;
    localparam int BTN_UP = 8;
    localparam int BTN_D0 = 9;
    localparam int BTN_STAR = 19;
    localparam int BTN_HASH = 20;
    localparam logic [4:0] BTN_NONE = 5'd31;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    // col 0..3 = col1..col4, row 0..5 = row1..row6; unwired positions map to BTN_NONE
    function automatic logic [4:0] btn_map(input logic [1:0] col, input logic [2:0] row);
        logic [5:0][4:0] m;
        m = col == 2'd0 ? {5'(BTN_HASH), 5'(BTN_D0 + 9), 5'(BTN_D0 + 6), 5'(BTN_D0 + 3), 5'(BTN_OPTION), BTN_NONE}
          : col == 2'd1 ? {5'(BTN_D0), 5'(BTN_D0 + 8), 5'(BTN_D0 + 5), 5'(BTN_D0 + 2), 5'(BTN_C), BTN_NONE}
          : col == 2'd2 ? {5'(BTN_STAR), 5'(BTN_D0 + 7), 5'(BTN_D0 + 4), 5'(BTN_D0 + 1), 5'(BTN_B), BTN_NONE}
          : {5'(BTN_UP), 5'(BTN_DOWN), 5'(BTN_LEFT), 5'(BTN_RIGHT), 5'(BTN_A), 5'(BTN_PAUSE)};
        return m[row];
    endfunction
endpackage

// File: rtl/jag_sync2.sv
// jag_sync2: parameterised-width two-flop synchroniser for asynchronous inputs
module jag_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        meta <= d;
        q <= meta;
    end
endmodule

// File: rtl/jag_joypad_scanner.sv
// jag_joypad_scanner: scans the joypad matrix one column per window and debounces whole frames
module jag_joypad_scanner
    import jag_pad_pkg::*;
#(
    parameter int SETTLE_CYCLES = 8,
    parameter int SCAN_PERIOD = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   scan_en,
    output logic [3:0]             col_n,
    input  logic [5:0]             row_n,
    output logic [NUM_BUTTONS-1:0] buttons,
    output logic                   valid,
    output logic                   changed
);
    localparam int PW = $clog2(SCAN_PERIOD);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    state_t state, state_nx;
    logic [PW-1:0] period;
    logic [CW-1:0] cnt;
    logic [1:0] col_idx;
    logic [5:0] rows;
    logic [NUM_BUTTONS-1:0] scan, prev_scan, scan_nx;
    logic [4:0] b;
    logic tick, sample;

    jag_sync2 #(.WIDTH(6)) u_sync (.clk(clk), .d(row_n), .q(rows));

    assign tick = period == PW'(SCAN_PERIOD - 1);
    assign sample = state == SCAN && cnt == CW'(SETTLE_CYCLES);

    always_ff @(posedge clk) begin
        if (reset) period <= '0;
        else period <= tick ? '0 : period + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE ? (tick && scan_en ? SCAN : IDLE)
                 : state == SCAN ? (sample && col_idx == 2'd3 ? COMMIT : SCAN)
                 : IDLE;
    end

    always_comb begin
        col_n = state == SCAN ? ~(4'b0001 << col_idx) : 4'b1111;
    end

    // merge the active column's inverted rows into the frame being assembled
    always_comb begin
        scan_nx = scan;
        b = BTN_NONE;
        for (int r = 0; r < 6; r++) begin
            b = btn_map(col_idx, 3'(r));
            if (b != BTN_NONE) scan_nx[b] = ~rows[r];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            col_idx <= '0;
            scan <= '0;
            prev_scan <= '0;
            buttons <= '0;
            valid <= 1'b0;
            changed <= 1'b0;
        end else begin
            cnt <= state == SCAN && !sample ? cnt + 1'b1 : '0;
            valid <= state == COMMIT;
            changed <= state == COMMIT && scan == prev_scan && scan != buttons;
            if (sample) begin
                scan <= scan_nx;
                col_idx <= col_idx + 1'b1;
            end
            if (state == COMMIT) begin
                prev_scan <= scan;
                if (scan == prev_scan) buttons <= scan;
            end
        end
    end
endmodule

// File: tb/tb_jag_joypad_scanner.sv
// tb_jag_joypad_scanner: pad model driving random frames, checked against a frame-level debounce model
module tb_jag_joypad_scanner;
    localparam int S = 3;
    localparam int P = 32;
    localparam int VALID_PH = 4 * (S + 1) + 2;
    localparam logic [4:0] X = 5'd31;
    localparam logic [4:0] MAP [4][6] = '{
        '{X,    5'd4, 5'd12, 5'd15, 5'd18, 5'd20},
        '{X,    5'd3, 5'd11, 5'd14, 5'd17, 5'd9},
        '{X,    5'd2, 5'd10, 5'd13, 5'd16, 5'd19},
        '{5'd0, 5'd1, 5'd5,  5'd6,  5'd7,  5'd8}};

    logic clk = 0, reset = 1, scan_en = 0;
    logic [3:0] col_n;
    logic [5:0] row_n;
    logic [20:0] buttons;
    logic valid, changed;
    logic [20:0] pad = 0;
    logic [5:0] junk = 0;
    int cyc = 0;
    logic in_frame = 0;
    logic [20:0] frame_val = 0, exp_btn = 0, exp_prev = 0;
    logic exp_valid = 0, exp_ch = 0;
    int n_vec = 0, n_bad = 0, n_valid = 0, n_col_act = 0;
    int ph;
    logic [3:0] exp_col;
    logic [20:0] v_btn;
    logic v_ch;
    int v_ph;

    jag_joypad_scanner #(.SETTLE_CYCLES(S), .SCAN_PERIOD(P)) dut (
        .clk(clk), .reset(reset), .scan_en(scan_en), .col_n(col_n),
        .row_n(row_n), .buttons(buttons), .valid(valid), .changed(changed)
    );

    always #5 clk = ~clk;

    // pad: a pressed button pulls its row low while its column is selected; unwired rows float randomly
    always_comb begin
        row_n = junk;
        for (int c = 0; c < 4; c++)
            if (!col_n[c])
                for (int r = 0; r < 6; r++)
                    row_n[r] = MAP[c][r] == X ? junk[r] : ~pad[MAP[c][r]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // frame-level reference: a frame's value is adopted only when it equals the previous frame
    always @(posedge clk) begin
        if (reset) begin
            cyc <= 0;
            in_frame <= 0;
            exp_btn <= 0;
            exp_prev <= 0;
            exp_valid <= 0;
            exp_ch <= 0;
        end else begin
            cyc <= cyc + 1;
            exp_valid <= 0;
            exp_ch <= 0;
            if (cyc % P == P - 1) begin
                in_frame <= scan_en;
                frame_val <= pad;
            end
            if (in_frame && cyc % P == VALID_PH - 2) begin
                exp_valid <= 1;
                if (frame_val == exp_prev) begin
                    exp_ch <= frame_val != exp_btn;
                    exp_btn <= frame_val;
                end
                exp_prev <= frame_val;
            end
        end
    end

    always @(negedge clk) begin
        ph = cyc % P + 1;
        exp_col = in_frame && ph <= 4 * (S + 1) ? ~(4'h1 << ((ph - 1) / (S + 1))) : 4'hF;
        check("col_n", 32'(col_n), 32'(exp_col));
        check("valid", 32'(valid), 32'(exp_valid));
        check("changed", 32'(changed), 32'(exp_ch));
        check("buttons", 32'(buttons), 32'(exp_btn));
        if (valid) n_valid++;
        if (col_n != 4'hF) n_col_act++;
    end

    task automatic frame_done();
        int t = 0;
        @(negedge clk);
        while (!valid && t < 2 * P) begin
            @(negedge clk);
            t++;
        end
        check("valid_seen", 32'(valid), 32'd1);
        v_btn = buttons;
        v_ch = changed;
        v_ph = cyc % P + 1;
        @(negedge clk);
        junk = 6'($urandom());
    endtask

    task automatic wait_phase(input int k);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (cyc % P != k && t < 2 * P);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 0;
        repeat (100) @(negedge clk);
        check("idle_no_valid", 32'(n_valid), 32'd0);
        check("idle_no_col", 32'(n_col_act), 32'd0);
        pad = 21'h2;
        scan_en = 1;
        frame_done();
        check("a_f1_btn", 32'(v_btn), 32'd0);
        check("a_f1_ch", 32'(v_ch), 32'd0);
        frame_done();
        check("a_f2_btn", 32'(v_btn), 32'h2);
        check("a_f2_ch", 32'(v_ch), 32'd1);
        check("a_f2_cycle", 32'(v_ph), 32'd18);
        pad = 21'h100001;
        frame_done();
        frame_done();
        check("hp_btn", 32'(v_btn), 32'h100001);
        check("hp_ch", 32'(v_ch), 32'd1);
        pad = 0;
        frame_done();
        check("rel1_btn", 32'(v_btn), 32'h100001);
        frame_done();
        check("rel2_btn", 32'(v_btn), 32'd0);
        check("rel2_ch", 32'(v_ch), 32'd1);
        frame_done();
        pad = 21'h1 << 14;
        frame_done();
        check("glitch_btn", 32'(v_btn), 32'd0);
        pad = 0;
        frame_done();
        check("glitch_ch", 32'(v_ch), 32'd0);
        frame_done();
        check("glitch_btn2", 32'(v_btn), 32'd0);
        repeat (24) begin
            pad = $urandom_range(0, 3) == 0 ? 21'(1 << $urandom_range(0, 20)) : 21'($urandom());
            repeat ($urandom_range(1, 3)) frame_done();
        end
        wait_phase(5);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("rst_col", 32'(col_n), 32'hF);
        check("rst_btn", 32'(buttons), 32'd0);
        n_valid = 0;
        repeat (P - 2) @(negedge clk);
        check("rst_no_valid", 32'(n_valid), 32'd0);
        pad = 21'h80000;
        frame_done();
        frame_done();
        check("post_rst_btn", 32'(v_btn), 32'h80000);
        wait_phase(4);
        scan_en = 0;
        n_valid = 0;
        frame_done();
        check("drop_btn", 32'(v_btn), 32'h80000);
        n_valid = 0;
        n_col_act = 0;
        repeat (3 * P) @(negedge clk);
        check("drop_no_valid", 32'(n_valid), 32'd0);
        check("drop_no_col", 32'(n_col_act), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
